block_matrix_multiplier: RTL
============================

# block_matrix_multiplier

Parametrised successor of the fixed 2×2-block matrix multiplier top. Computes C = A·B for square N×N signed matrices held in a single-port RAM, tiling the work into 2×2 blocks with an internal block multiply-accumulate unit. Results are written back to the same RAM. Adds configurable dimension and base addresses, on-chip accumulation across the k dimension, and overflow detection with optional saturation.

## Interface
- DATA_W, 32, element width, signed two's complement
- N, 4, matrix dimension; even, ≥2
- ADDR_W, 9, RAM address width
- A_BASE, 0, word address of A(0,0)
- B_BASE, 64, word address of B(0,0)
- C_BASE, 128, word address of C(0,0)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a multiply; sampled only in IDLE
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
- ram_addr  out  ADDR_W  RAM word address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- done  out  1  one-cycle completion pulse
- err  out  1  sticky overflow flag

## Operation
- Storage row-major: X(r,c) at X_BASE + r·N + c. All addresses are assumed in range; out-of-range is a configuration error, not checked.
- Loop order: bi (block row), bj (block col), bk (inner), each 0..N/2−1; bk innermost.
- States: IDLE → LOAD → MAC → (LOAD if bk < N/2−1, else WR) → (LOAD for next (bi,bj), else DONE) → IDLE.
- IDLE: ram_we=0; on start=1: clear err, clear accumulators, indices to 0, go LOAD.
- LOAD (9 cycles): cycles 0–3 issue A(2bi+i, 2bk+j) in order 11,12,21,22; cycles 4–7 issue B(2bk+i, 2bj+j) same order; data captured into a/b registers one cycle after each address; cycle 8 captures last B word.
- MAC (1 cycle): acc_ij += Σk a_ik·b_kj for all four elements in parallel; products and sums computed at full width, then reduced to DATA_W.
- WR (4 cycles): ram_we=1, writes acc11, acc12, acc21, acc22 to C(2bi+i, 2bj+j); accumulators cleared at exit.
- DONE (1 cycle): done=1, then IDLE.
- Overflow: if any accumulated element result lies outside the signed DATA_W range, err is set and stays set until the next accepted start or rst.
- start while not IDLE ignored; start high in DONE ignored.

## Timing
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, done=0, err=0; state IDLE; accumulators 0.
- start sampled at edge t → first read address driven in cycle t+1.
- Per output block: (N/2)·10 + 4 cycles. done high exactly in cycle t+1+(N/2)²·(5N+4); N=2 → t+15, N=4 → t+97.
- ram_rdata of address driven in cycle c sampled at end of cycle c+1.
- ram_we asserted only in WR; ram_addr/ram_wdata stable while ram_we=1.
- rst mid-operation: next cycle in IDLE, ram_we=0, done=0, err=0, no further RAM writes; partial C contents undefined.
- err updates at the MAC edge that produces the overflow; visible next cycle.

## Configuration
- BMM_SATURATE_EN defined: overflowing element results clamp to +2^(DATA_W−1)−1 or −2^(DATA_W−1); accumulation continues from the clamped value.
- Not defined: results wrap modulo 2^DATA_W.
- err behaviour identical in both builds.

## Test plan
- N=2, A=[1,2;3,4] at 0, B=[5,6;7,8] at 64 → C_BASE..+3 = 19,22,43,50; done single pulse at t+15; err=0.
- N=4, A=identity, B=values 1..16 → C equals B word-for-word; done at t+97; exactly 16 ram_we cycles.
- DATA_W=8, N=2, A=[100,0;0,1], B=[2,0;0,1] → err=1; C11=0xC8 (−56) without BMM_SATURATE_EN, 0x7F with it; C22=1.
- start re-pulsed mid-run at t+5 → ignored; single done at t+15; results unchanged.
- rst asserted at t+8 for one cycle → no ram_we afterwards, done never pulses, err=0; new start then completes normally.
- Overflow run followed by a clean run → err cleared in the cycle after the new start is accepted and stays 0.

Source files
------------

// File: rtl/block_matrix_multiplier.sv
// block_matrix_multiplier
// Computes C = A*B for square N x N signed matrices stored row-major in a
// single-port RAM (one-cycle read latency). Work is tiled into 2x2 blocks:
// for each output block (bi,bj) the A and B tiles for every bk are loaded,
// multiply-accumulated on chip, and the finished block is written back.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a multiply (sampled only in IDLE)
//   ram_rdata  RAM read data, valid one cycle after ram_addr
//   ram_addr   RAM word address
//   ram_we     RAM write enable (only while writing a C block)
//   ram_wdata  RAM write data
//   done       one-cycle completion pulse
//   err        sticky overflow flag, cleared by rst or an accepted start
//
// Build option: define BMM_SATURATE_EN to clamp overflowing element results
// to the signed DATA_W range; otherwise results wrap modulo 2^DATA_W.

module block_matrix_multiplier #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N      = 4,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned A_BASE = 0,
   parameter int unsigned B_BASE = 64,
   parameter int unsigned C_BASE = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              done,
   output logic              err
);

   localparam int unsigned NB     = N / 2;
   localparam int unsigned IDX_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned FULL_W = 2 * DATA_W + 2;
   localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(NB - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WR, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [IDX_W-1:0]         bi_q, bi_d, bj_q, bj_d, bk_q, bk_d;
   logic signed [DATA_W-1:0] a_q [4];
   logic signed [DATA_W-1:0] a_d [4];
   logic signed [DATA_W-1:0] b_q [4];
   logic signed [DATA_W-1:0] b_d [4];
   logic signed [DATA_W-1:0] acc_q [4];
   logic signed [DATA_W-1:0] acc_d [4];
   logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
   logic                     ram_we_q, ram_we_d;
   logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;

   logic signed [FULL_W-1:0] sum_full [4];
   logic signed [DATA_W-1:0] acc_new [4];
   logic [3:0]               ovf;
   logic [3:0]               widx;

   // Row-major word address of X(row,col).
   function automatic logic [ADDR_W-1:0] elem_addr(input int unsigned base,
                                                   input int unsigned row,
                                                   input int unsigned col);
      return ADDR_W'(base + row * N + col);
   endfunction

   // Load word w: 0..3 are A(2bi+i,2bk+j), 4..7 are B(2bk+i,2bj+j), order 11,12,21,22.
   function automatic logic [ADDR_W-1:0] load_addr(input logic [3:0]       w,
                                                   input logic [IDX_W-1:0] bi,
                                                   input logic [IDX_W-1:0] bj,
                                                   input logic [IDX_W-1:0] bk);
      if (!w[2]) return elem_addr(A_BASE, 2 * 32'(bi) + 32'(w[1]), 2 * 32'(bk) + 32'(w[0]));
      else       return elem_addr(B_BASE, 2 * 32'(bk) + 32'(w[1]), 2 * 32'(bj) + 32'(w[0]));
   endfunction

   function automatic logic [ADDR_W-1:0] c_addr(input logic [1:0]       e,
                                                input logic [IDX_W-1:0] bi,
                                                input logic [IDX_W-1:0] bj);
      return elem_addr(C_BASE, 2 * 32'(bi) + 32'(e[1]), 2 * 32'(bj) + 32'(e[0]));
   endfunction

   // acc + a0*b0 + a1*b1 at a width that cannot overflow.
   function automatic logic signed [FULL_W-1:0] dot(input logic signed [DATA_W-1:0] acc,
                                                    input logic signed [DATA_W-1:0] a0,
                                                    input logic signed [DATA_W-1:0] a1,
                                                    input logic signed [DATA_W-1:0] b0,
                                                    input logic signed [DATA_W-1:0] b1);
      return FULL_W'(acc) + FULL_W'(a0) * FULL_W'(b0) + FULL_W'(a1) * FULL_W'(b1);
   endfunction

   // Block MAC: full-width sums, overflow detect, reduction to DATA_W.
   always_comb begin
      sum_full[0] = dot(acc_q[0], a_q[0], a_q[1], b_q[0], b_q[2]);
      sum_full[1] = dot(acc_q[1], a_q[0], a_q[1], b_q[1], b_q[3]);
      sum_full[2] = dot(acc_q[2], a_q[2], a_q[3], b_q[0], b_q[2]);
      sum_full[3] = dot(acc_q[3], a_q[2], a_q[3], b_q[1], b_q[3]);
      for (int e = 0; e < 4; e++) begin
         // In range iff every bit from DATA_W-1 upward equals the sign.
         ovf[e] = !((&sum_full[e][FULL_W-1:DATA_W-1]) || !(|sum_full[e][FULL_W-1:DATA_W-1]));
`ifdef BMM_SATURATE_EN
         if (ovf[e])
            acc_new[e] = sum_full[e][FULL_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                               : {1'b0, {(DATA_W-1){1'b1}}};
         else
            acc_new[e] = sum_full[e][DATA_W-1:0];
`else
         acc_new[e] = sum_full[e][DATA_W-1:0];
`endif
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bi_d        = bi_q;
      bj_d        = bj_q;
      bk_d        = bk_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      done_d      = 1'b0;
      err_d       = err_q;
      widx        = cnt_q - 4'd1;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d      = 1'b0;
               for (int e = 0; e < 4; e++) acc_d[e] = '0;
               bi_d       = '0;
               bj_d       = '0;
               bk_d       = '0;
               cnt_d      = '0;
               ram_addr_d = load_addr(4'd0, '0, '0, '0);
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            // Word issued in cycle c-1 arrives in cycle c.
            if (cnt_q != 4'd0) begin
               if (!widx[2]) a_d[widx[1:0]] = ram_rdata;
               else          b_d[widx[1:0]] = ram_rdata;
            end
            if (cnt_q < 4'd7) ram_addr_d = load_addr(cnt_q + 4'd1, bi_q, bj_q, bk_q);
            if (cnt_q == 4'd8) begin
               cnt_d   = '0;
               state_d = S_MAC;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_MAC: begin
            acc_d = acc_new;
            err_d = err_q | (|ovf);
            if (bk_q != LAST_BLK) begin
               bk_d       = bk_q + IDX_W'(1);
               ram_addr_d = load_addr(4'd0, bi_q, bj_q, bk_q + IDX_W'(1));
               state_d    = S_LOAD;
            end else begin
               // First write uses the freshly accumulated value.
               ram_we_d    = 1'b1;
               ram_addr_d  = c_addr(2'd0, bi_q, bj_q);
               ram_wdata_d = acc_new[0];
               state_d     = S_WR;
            end
         end
         S_WR: begin
            if (cnt_q != 4'd3) begin
               ram_we_d    = 1'b1;
               ram_addr_d  = c_addr(cnt_q[1:0] + 2'd1, bi_q, bj_q);
               ram_wdata_d = acc_q[cnt_q[1:0] + 2'd1];
               cnt_d       = cnt_q + 4'd1;
            end else begin
               cnt_d = '0;
               bk_d  = '0;
               for (int e = 0; e < 4; e++) acc_d[e] = '0;
               if (bj_q != LAST_BLK) begin
                  bj_d       = bj_q + IDX_W'(1);
                  ram_addr_d = load_addr(4'd0, bi_q, bj_q + IDX_W'(1), '0);
                  state_d    = S_LOAD;
               end else if (bi_q != LAST_BLK) begin
                  bi_d       = bi_q + IDX_W'(1);
                  bj_d       = '0;
                  ram_addr_d = load_addr(4'd0, bi_q + IDX_W'(1), '0, '0);
                  state_d    = S_LOAD;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bi_q        <= '0;
         bj_q        <= '0;
         bk_q        <= '0;
         a_q         <= '{default: '0};
         b_q         <= '{default: '0};
         acc_q       <= '{default: '0};
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bi_q        <= bi_d;
         bj_q        <= bj_d;
         bk_q        <= bk_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
